morse_letter_sequencer: RTL and testbench
=========================================

// Module: morse_letter_sequencer
// PURPOSE
//  Upstream controller for the 11-bit Morse shift register. Latches a letter code (A-H),
//  drives its LSB-first unit pattern onto the register's data_in, and issues the
//  enable (load), shift-clock and clear strobes. Each unit lasts TICK_CYCLES clocks,
//  followed by an inter-letter gap, so the register's bit[0] shows the Morse symbol on the LED.
// PARAMETERS
//  TICK_CYCLES  25_000_000  clocks per Morse unit (0.5 s at 50 MHz); >= 2
//  GAP_UNITS    3           silent units after the clear pulse before done; >= 1
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst          in   1   synchronous reset, active-high
//  start        in   1   request to send letter; sampled only in IDLE
//  letter       in   3   0=A 1=B 2=C 3=D 4=E 5=F 6=G 7=H; sampled with start
//  pattern      out  11  unit pattern to shift-register data_in (1=lit unit, LSB first)
//  pattern_len  out  4   number of units in pattern (1..11)
//  sr_enable    out  1   1-cycle strobe: shift register loads pattern
//  sr_shift     out  1   1-cycle strobe: shift register shifts right one unit
//  sr_clear     out  1   1-cycle strobe: shift register clears to 0
//  busy         out  1   high while a letter or its gap is in progress
//  done         out  1   1-cycle strobe: letter and gap complete
// BEHAVIOUR
//  - Reset: while rst=1, all outputs are 0 and the state is CLR. On the first clock after rst
//    deasserts, sr_clear=1 for one cycle (also when rst aborts a letter mid-send), then IDLE.
//  - Table (dot=1, dash=111, 0 between elements, no trailing 0):
//    A 0x01D/5  B 0x157/9  C 0x5D7/11  D 0x057/7  E 0x001/1  F 0x175/9  G 0x177/9  H 0x055/7
//  - pattern/pattern_len: registered from letter latched at start; held until the next start.
//    They read 0 after reset until the first start.
//  - FSM: CLR -> IDLE -> LOAD -> SHOW -> GAP -> IDLE. All strobe outputs are registered.
//  - IDLE with start=1 at edge N: latch letter. sr_enable=1 and busy=1 in cycle N+1.
//  - Unit k (k=0..len-1) starts at cycle N+1+k*T, where T=TICK_CYCLES.
//    sr_shift=1 at N+1+k*T for k=1..len-1 (exactly len-1 shifts).
//  - sr_clear=1 at N+1+len*T. GAP then lasts GAP_UNITS*T cycles.
//  - done=1 at N+1+(len+GAP_UNITS)*T, with busy=0 in that cycle. busy=1 from N+1 to that cycle-1.
//  - start while busy, or in the CLR cycle: ignored, not queued. start in the done cycle: accepted
//    (the block is in IDLE), so the next sr_enable is in the cycle after done.
//  - Strobes are mutually exclusive. Exactly one strobe per unit boundary; none in other cycles.
//  - Prescaler width is $clog2(TICK_CYCLES). Counters saturate at terminal values and never wrap
//    mid-unit. The prescaler restarts at 0 on every unit boundary.
//  - letter changes while busy have no effect on pattern or timing.
// TESTING (bench uses TICK_CYCLES=4, GAP_UNITS=3)
//  - Reset: rst held 3 cycles, then released -> all outputs 0 during rst; sr_clear=1 exactly
//    1 cycle after release; busy=0.
//  - Letter E: start=1, letter=4 at edge N -> pattern=0x001, pattern_len=1; sr_enable@N+1;
//    no sr_shift; sr_clear@N+5; done@N+17; busy high N+1..N+16.
//  - Letter A: letter=0 -> pattern=0x01D; sr_shift@N+5,N+9,N+13,N+17; sr_clear@N+21;
//    done@N+33. A shift-register model's bit0 reads 1,0,1,1,1 per unit.
//  - Letter C: letter=2 -> pattern=0x5D7, len=11; 10 sr_shift pulses; sr_clear@N+45;
//    done@N+57. Model bit0 matches the C table sequence.
//  - Start while busy: second start (letter=7) at N+10 during A -> ignored; pattern stays 0x01D;
//    timing unchanged. Start in the done cycle -> sr_enable in the next cycle.
//  - Abort: rst=1 at N+11 during B -> outputs 0 next cycle; after release, sr_clear 1 cycle,
//    then IDLE. Next start sends from unit 0.

Source files
------------

// File: rtl/morse_letter_sequencer_if.sv
// Handshake/bus bundle between the letter requester and the Morse letter sequencer.
interface morse_letter_sequencer_if;
  logic        start;
  logic [2:0]  letter;
  logic [10:0] pattern;
  logic [3:0]  pattern_len;
  logic        sr_enable;
  logic        sr_shift;
  logic        sr_clear;
  logic        busy;
  logic        done;

  modport master (
    output start, letter,
    input  pattern, pattern_len, sr_enable, sr_shift, sr_clear, busy, done
  );

  modport slave (
    input  start, letter,
    output pattern, pattern_len, sr_enable, sr_shift, sr_clear, busy, done
  );
endinterface

// File: rtl/morse_letter_sequencer.sv
// Morse letter sequencer: latches a letter (A-H), loads its LSB-first unit pattern
// into the downstream 11-bit shift register, shifts once per unit, clears it,
// then waits an inter-letter gap before signalling done.
module morse_letter_sequencer #(
  parameter int unsigned TICK_CYCLES = 25_000_000,
  parameter int unsigned GAP_UNITS   = 3
) (
  input logic                      clk,
  input logic                      rst,
  morse_letter_sequencer_if.slave  bus
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam int unsigned GW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_UNITS - 1);

  typedef enum logic [2:0] {CLR, IDLE, LOAD, SHOW, GAP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    unit_q, unit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [10:0]   pattern_q, pattern_d;
  logic [3:0]    len_q, len_d;
  logic          en_q, en_d, sh_q, sh_d, cl_q, cl_d, dn_q, dn_d, busy_q, busy_d;

  // {pattern_len, pattern}: dot=1, dash=111, single 0 between elements
  function automatic logic [14:0] lookup(input logic [2:0] l);
    case (l)
      3'd0:    return {4'd5,  11'h01D};
      3'd1:    return {4'd9,  11'h157};
      3'd2:    return {4'd11, 11'h5D7};
      3'd3:    return {4'd7,  11'h057};
      3'd4:    return {4'd1,  11'h001};
      3'd5:    return {4'd9,  11'h175};
      3'd6:    return {4'd9,  11'h177};
      default: return {4'd7,  11'h055};
    endcase
  endfunction

  // Next-state, counters and next strobe values; LOAD is the first cycle of unit 0
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    unit_d    = unit_q;
    gap_d     = gap_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    en_d      = 1'b0;
    sh_d      = 1'b0;
    cl_d      = 1'b0;
    dn_d      = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      CLR: begin
        state_d = IDLE;
        cl_d    = 1'b1;
      end
      IDLE: begin
        if (bus.start) begin
          state_d              = LOAD;
          {len_d, pattern_d}   = lookup(bus.letter);
          en_d                 = 1'b1;
          busy_d               = 1'b1;
          presc_d              = '0;
          unit_d               = '0;
        end
      end
      LOAD: begin
        state_d = SHOW;
        busy_d  = 1'b1;
        presc_d = presc_q + 1'b1;
      end
      SHOW: begin
        busy_d = 1'b1;
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (unit_q == len_q - 4'd1) begin
            state_d = GAP;
            cl_d    = 1'b1;
            gap_d   = '0;
          end else begin
            unit_d = unit_q + 4'd1;
            sh_d   = 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          if (gap_q == GAP_LAST) begin
            state_d = IDLE;
            dn_d    = 1'b1;
            busy_d  = 1'b0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = CLR;
    endcase
  end

  // State and registered outputs; reset forces CLR with every output low
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLR;
      presc_q   <= '0;
      unit_q    <= '0;
      gap_q     <= '0;
      pattern_q <= '0;
      len_q     <= '0;
      en_q      <= 1'b0;
      sh_q      <= 1'b0;
      cl_q      <= 1'b0;
      dn_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      unit_q    <= unit_d;
      gap_q     <= gap_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      en_q      <= en_d;
      sh_q      <= sh_d;
      cl_q      <= cl_d;
      dn_q      <= dn_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.pattern     = pattern_q;
  assign bus.pattern_len = len_q;
  assign bus.sr_enable   = en_q;
  assign bus.sr_shift    = sh_q;
  assign bus.sr_clear    = cl_q;
  assign bus.done        = dn_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Bench for morse_letter_sequencer: strobe scoreboard keyed by cycle number,
// busy window model and a downstream shift-register model fed by the strobes.
module tb_morse_letter_sequencer;

  localparam int T   = 4;
  localparam int GAP = 3;

  typedef struct { int cyc; int kind; } ev_t;  // kind: 0 enable, 1 shift, 2 clear, 3 done

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  q[$];
  int   busy_lo = 0;
  int   busy_hi = 0;
  logic [10:0] exp_pat = '0;
  int   exp_len = 0;
  logic [10:0] srm = '0;
  int   k = 0;
  string code [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};

  morse_letter_sequencer_if bus ();

  morse_letter_sequencer #(.TICK_CYCLES(T), .GAP_UNITS(GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Independent pattern model built from dot/dash text
  task automatic build(input string m, output logic [10:0] p, output int len);
    int pos = 0;
    p = '0;
    for (int i = 0; i < m.len(); i++) begin
      if (i > 0) pos++;
      if (m[i] == ".") begin
        p[pos] = 1'b1;
        pos++;
      end else begin
        for (int j = 0; j < 3; j++) p[pos + j] = 1'b1;
        pos += 3;
      end
    end
    len = pos;
  endtask

  // Monitor: sampled 1 time unit after each active edge; s is the cycle those outputs belong to
  always @(posedge clk) begin
    int s, nstb, kind;
    ev_t e;
    #1;
    s    = cyc + 1;
    nstb = int'(bus.sr_enable) + int'(bus.sr_shift) + int'(bus.sr_clear) + int'(bus.done);
    if (nstb > 1) chk("strobe_exclusive", nstb, 1);
    while (q.size() > 0 && q[0].cyc < s) begin
      chk("missed_strobe_cycle", s, q[0].cyc);
      void'(q.pop_front());
    end
    if (nstb >= 1) begin
      kind = bus.sr_enable ? 0 : bus.sr_shift ? 1 : bus.sr_clear ? 2 : 3;
      if (q.size() == 0) begin
        chk("spurious_strobe_kind", kind, -1);
      end else begin
        e = q.pop_front();
        chk("strobe_cycle", s, e.cyc);
        chk("strobe_kind", kind, e.kind);
      end
    end
    chk("busy", int'(bus.busy), int'(s >= busy_lo && s < busy_hi));
    if (bus.sr_enable) begin
      chk("pattern", int'(bus.pattern), int'(exp_pat));
      chk("pattern_len", int'(bus.pattern_len), exp_len);
      srm = bus.pattern;
      k   = 0;
      chk("unit_bit0", int'(srm[0]), int'(exp_pat[0]));
    end
    if (bus.sr_shift) begin
      srm = srm >> 1;
      k++;
      if (k < 11) chk("unit_bit0", int'(srm[0]), int'(exp_pat[k]));
    end
    if (bus.sr_clear) srm = '0;
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; start is sampled at the next edge n
  task automatic send(input int l, output int n);
    n = cyc + 1;
    build(code[l], exp_pat, exp_len);
    q.push_back('{n + 1, 0});
    for (int u = 1; u < exp_len; u++) q.push_back('{n + 1 + u * T, 1});
    q.push_back('{n + 1 + exp_len * T, 2});
    q.push_back('{n + 1 + (exp_len + GAP) * T, 3});
    busy_lo = n + 1;
    busy_hi = n + 1 + (exp_len + GAP) * T;
    bus.letter = 3'(l);
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  initial begin
    int n, n2;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.letter = '0;

    // Reset: everything low while held
    repeat (3) begin
      @(negedge clk);
      chk("rst_pattern", int'(bus.pattern), 0);
      chk("rst_len", int'(bus.pattern_len), 0);
      chk("rst_strobes", int'({bus.sr_enable, bus.sr_shift, bus.sr_clear, bus.done}), 0);
      chk("rst_busy", int'(bus.busy), 0);
    end
    rst = 1'b0;
    q.push_back('{cyc + 2, 2});
    // start during the CLR cycle must be ignored
    bus.start  = 1'b1;
    bus.letter = 3'd4;
    @(negedge clk);
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);
    chk("clr_start_ignored_len", int'(bus.pattern_len), 0);

    // Letter E
    send(4, n);
    chk("E_pattern", int'(bus.pattern), 'h001);
    wait_until(n + 20);

    // Letter A, with an ignored start (H) mid-letter and a start in the done cycle (C)
    send(0, n);
    wait_until(n + 9);
    bus.letter = 3'd7;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    chk("busy_start_pattern", int'(bus.pattern), 'h01D);
    wait_until(n + 30);
    bus.letter = 3'd5;
    wait_until(n + 32);
    chk("A_done_visible", int'(bus.done), 1);
    send(2, n2);
    chk("C_start_at_done", n2, n + 33);
    chk("C_pattern", int'(bus.pattern), 'h5D7);
    wait_until(n2 + 60);

    // Abort B mid-letter with reset
    send(1, n);
    wait_until(n + 10);
    rst = 1'b1;
    while (q.size() > 0 && q[$].cyc > n + 11) void'(q.pop_back());
    busy_hi = n + 12;
    @(negedge clk);
    chk("abort_pattern", int'(bus.pattern), 0);
    chk("abort_len", int'(bus.pattern_len), 0);
    chk("abort_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    q.push_back('{cyc + 2, 2});
    repeat (3) @(negedge clk);

    // Letter D after abort, from unit 0
    send(3, n);
    chk("D_pattern", int'(bus.pattern), 'h057);
    chk("D_len", int'(bus.pattern_len), 7);
    wait_until(n + 45);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
